cover_toggle_detect: RTL and testbench
======================================

# cover_toggle_detect

Per-bit toggle detector that drives the `valid` vector of the toggle-coverage reporter. It watches a WIDTH-bit DUT signal bundle and records, for each bit, a rising and a falling transition. When a bit has seen both directions, it emits a one-cycle `valid` pulse for that bit. It sits directly upstream of the coverage reporter; `valid` connects straight to that reporter's `valid` input, with the same `clock` and `reset`.

## Interface
- `WIDTH`, 65 — number of watched bits; also the width of `valid`
- `WARMUP_CYCLES`, 4 — cycles after reset or `clear` during which transitions are ignored; range 0..255
- `clock` in 1 — single clock; all logic on posedge
- `reset` in 1 — synchronous, active-high
- `sig` in WIDTH — watched DUT bits, sampled every posedge
- `en` in 1 — when 0, transitions are not recorded, but the previous-sample register still tracks `sig`
- `clear` in 1 — single-cycle pulse; wipes seen/covered state and re-enters WARMUP
- `valid` out WIDTH — per-bit pulse; bit i is high for exactly one cycle when bit i completes a toggle
- `covered_cnt` out $clog2(WIDTH+1) — number of bits covered since the last reset or `clear`
- `all_covered` out 1 — high while `covered_cnt == WIDTH`

## Operation
- States:
  - WARMUP: counter runs 0..WARMUP_CYCLES-1.
  - PRIME: one cycle; loads `prev <= sig`.
  - RUN.
- Transitions:
  - reset or `clear` → WARMUP.
  - WARMUP → PRIME when the counter reaches WARMUP_CYCLES-1. If WARMUP_CYCLES is 0, go directly to PRIME.
  - PRIME → RUN.
- In RUN, with `en`=1, per bit:
  - `rise = sig & ~prev`
  - `fall = ~sig & prev`
  - `rise_seen |= rise`
  - `fall_seen |= fall`
- Bit i completes when `rise_seen|rise` and `fall_seen|fall` are both set and `covered[i]` was 0.
  - On completion: set `covered[i]`; `valid[i]` pulses.
- `prev <= sig` on every posedge in PRIME and RUN, regardless of `en`.
- `covered_cnt` is incremented by the popcount of the newly completed bits, saturating at WIDTH (it cannot exceed WIDTH by construction). It is unsigned and zero-extended.
- `clear` priority:
  - `clear` overrides any completion in the same cycle: no `valid` pulse, and all counters and masks are zeroed.
  - `reset` overrides `clear`.
- All state is held in flops. `sig` is never used combinationally to drive outputs.

## Timing
- Reset values:
  - `valid` = 0, `covered_cnt` = 0, `all_covered` = 0.
  - `rise_seen`, `fall_seen`, `covered` and `prev` = 0.
  - State = WARMUP, warmup counter = 0.
- Latency: if the second transition of bit i is sampled at posedge k, `valid[i]` is high in the cycle after edge k and low after edge k+1.
- `covered_cnt` and `all_covered` update at that same edge k.
- First recordable transition: the first RUN-state edge, which is WARMUP_CYCLES+2 edges after reset deasserts. Transitions during WARMUP or PRIME are never recorded.
- Several bits completing at the same edge pulse together in the same cycle, and `covered_cnt` adds all of them.
- `en` deasserted mid-toggle: `prev` keeps tracking, so a transition that occurs while `en`=0 is lost, not deferred.
- `reset` or `clear` asserted mid-RUN: the next cycle is WARMUP with all masks zero, and no pulse is issued.

## Configuration
- `COVER_TOGGLE_REPEAT_EN`
  - Defined: after completing, bit i clears its own `rise_seen`/`fall_seen` (not `covered`). Every subsequent full rise+fall pair pulses `valid[i]` again. `covered_cnt` still counts distinct bits only.
  - Undefined (default): bit i pulses at most once between a reset/`clear` and the next reset/`clear`.

## Structure
- Shared package `cover_pkg` holds:
  - the state enum `toggle_state_t` {WARMUP, PRIME, RUN};
  - `COVER_CNT_W(w) = $clog2(w+1)`;
  - the warmup counter width constant (8).
- Sub-module `cover_popcount` (parameter `WIDTH`): a combinational adder tree that counts newly completed bits for the `covered_cnt` increment.

## Test plan
- Reset, WIDTH=65, WARMUP_CYCLES=4, `sig` toggling every cycle during warmup → `valid` stays 0 and `covered_cnt`=0 through the first RUN edge.
- In RUN, `sig[3]` goes 0→1 at edge k, then 1→0 at edge k+2 → `valid[3]` pulses exactly once, in the cycle after edge k+2; `covered_cnt`=1.
- `sig` = all ones, then all zeros on the next edge → `valid` = all 65 bits for one cycle; `covered_cnt`=65; `all_covered`=1.
- `clear` in the same cycle as the completing edge of bit 7 → no pulse; `covered_cnt`=0; state returns to WARMUP.
- `en`=0 during the fall of bit 10, with the rise already seen → no pulse. A later rise+fall with `en`=1 → a single pulse.
- With `COVER_TOGGLE_REPEAT_EN` defined, bit 0 toggles 0→1→0→1→0 → two `valid[0]` pulses; `covered_cnt` remains 1.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared types and sizing helpers for the toggle-coverage path.
// Imported by cover_toggle_detect and cover_popcount.
package cover_pkg;

    typedef enum logic [1:0] {
        WARMUP,
        PRIME,
        RUN
    } toggle_state_t;

    localparam int WARM_CNT_W = 8;

    function automatic int COVER_CNT_W(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cover_popcount.sv
// Combinational adder tree counting set bits of a vector.
// Recursively splits the vector in halves down to single bits.
module cover_popcount
    import cover_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic [WIDTH-1:0]                bits,
    output logic [COVER_CNT_W(WIDTH)-1:0]   count
);

    localparam int CW = COVER_CNT_W(WIDTH);

    if (WIDTH == 1) begin : g_leaf
        assign count = bits;
    end else begin : g_node
        localparam int LO  = WIDTH / 2;
        localparam int HI  = WIDTH - LO;
        localparam int LCW = COVER_CNT_W(LO);
        localparam int HCW = COVER_CNT_W(HI);

        logic [LCW-1:0] cnt_lo;
        logic [HCW-1:0] cnt_hi;

        cover_popcount #(.WIDTH(LO)) u_lo (
            .bits  (bits[LO-1:0]),
            .count (cnt_lo)
        );

        cover_popcount #(.WIDTH(HI)) u_hi (
            .bits  (bits[WIDTH-1:LO]),
            .count (cnt_hi)
        );

        assign count = CW'(cnt_lo) + CW'(cnt_hi);
    end

endmodule

// File: rtl/cover_toggle_detect.sv
// Per-bit rise+fall toggle detector feeding the coverage reporter.
// Optional COVER_TOGGLE_REPEAT_EN: re-arm each bit after it pulses.
module cover_toggle_detect
    import cover_pkg::*;
#(
    parameter int WIDTH         = 65,
    parameter int WARMUP_CYCLES = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                sig,
    input  logic                            en,
    input  logic                            clear,
    output logic [WIDTH-1:0]                valid,
    output logic [COVER_CNT_W(WIDTH)-1:0]   covered_cnt,
    output logic                            all_covered
);

    localparam int CW = COVER_CNT_W(WIDTH);
    localparam logic [CW:0] MAXC = (CW+1)'(WIDTH);
    localparam logic [WARM_CNT_W-1:0] WLAST =
        (WARMUP_CYCLES == 0) ? '0 : WARM_CNT_W'(WARMUP_CYCLES - 1);

    toggle_state_t          state;
    toggle_state_t          state_nxt;
    logic [WARM_CNT_W-1:0]  warm_cnt;
    logic                   warm_done;
    logic                   in_warm;
    logic                   in_prime;
    logic                   in_run;
    logic                   rec;

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_seen;
    logic [WIDTH-1:0] fall_seen;
    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] fs;
    logic [WIDTH-1:0] fire;
    logic [WIDTH-1:0] fresh;
    logic [WIDTH-1:0] keep;
    logic [CW-1:0]    fresh_cnt;
    logic [CW:0]      sum;

    assign warm_done = (WARMUP_CYCLES == 0) || (warm_cnt == WLAST);

    always_ff @(posedge clock) begin
        if (reset || clear)
            state <= WARMUP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WARMUP:  if (warm_done) state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = WARMUP;
        endcase
    end

    always_comb begin
        in_warm  = 1'b0;
        in_prime = 1'b0;
        in_run   = 1'b0;
        unique case (1'b1)
            (state == PRIME): in_prime = 1'b1;
            (state == RUN):   in_run   = 1'b1;
            default:          in_warm  = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear || !in_warm)
            warm_cnt <= '0;
        else if (!warm_done)
            warm_cnt <= warm_cnt + WARM_CNT_W'(1);
    end

    assign rec  = in_run & en;
    assign rise = sig & ~prev;
    assign fall = ~sig & prev;
    assign rs   = rise_seen | rise;
    assign fs   = fall_seen | fall;

`ifdef COVER_TOGGLE_REPEAT_EN
    // A completed bit re-arms so each later rise+fall pair pulses again.
    assign fire = rec ? (rs & fs) : '0;
    assign keep = ~fire;
`else
    assign fire = rec ? (rs & fs & ~covered) : '0;
    assign keep = '1;
`endif

    assign fresh = fire & ~covered;

    cover_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (fresh),
        .count (fresh_cnt)
    );

    assign sum = {1'b0, covered_cnt} + {1'b0, fresh_cnt};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prev        <= '0;
            rise_seen   <= '0;
            fall_seen   <= '0;
            covered     <= '0;
            valid       <= '0;
            covered_cnt <= '0;
        end else begin
            if (in_prime || in_run)
                prev <= sig;
            if (rec) begin
                rise_seen <= rs & keep;
                fall_seen <= fs & keep;
            end
            valid       <= fire;
            covered     <= covered | fresh;
            covered_cnt <= (sum > MAXC) ? MAXC[CW-1:0] : sum[CW-1:0];
        end
    end

    assign all_covered = (covered_cnt == MAXC[CW-1:0]);

endmodule

// File: tb/tb_cover_toggle_detect.sv
// Randomized + directed bench for cover_toggle_detect against a
// per-bit behavioural model of the toggle rules.
module tb_cover_toggle_detect;

    localparam int W    = 65;
    localparam int WARM = 4;
`ifdef COVER_TOGGLE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [W-1:0]  sig;
    logic          en;
    logic          clear;
    logic [W-1:0]  valid;
    logic [6:0]    covered_cnt;
    logic          all_covered;

    int n_cmp;
    int n_bad;

    int           m_edges;
    int           m_cnt;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_rs;
    logic [W-1:0] m_fs;
    logic [W-1:0] m_cov;
    logic [W-1:0] m_valid;

    logic [W-1:0] cur;
    logic [W-1:0] ones;

    cover_toggle_detect #(
        .WIDTH         (W),
        .WARMUP_CYCLES (WARM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .en          (en),
        .clear       (clear),
        .valid       (valid),
        .covered_cnt (covered_cnt),
        .all_covered (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] bit1(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Edge count since reset/clear decides when transitions are recordable.
    task automatic model_step(input logic [W-1:0] s, input logic e,
                              input logic c, input logic r);
        if (r || c) begin
            m_edges = 0;
            m_cnt   = 0;
            m_rs    = '0;
            m_fs    = '0;
            m_cov   = '0;
            m_valid = '0;
        end else begin
            m_edges++;
            m_valid = '0;
            if (e && m_edges >= WARM + 2) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] && !m_prev[i]) m_rs[i] = 1'b1;
                    if (!s[i] && m_prev[i]) m_fs[i] = 1'b1;
                    if (m_rs[i] && m_fs[i] && (REP || !m_cov[i])) begin
                        m_valid[i] = 1'b1;
                        if (!m_cov[i]) begin
                            m_cov[i] = 1'b1;
                            m_cnt++;
                        end
                        if (REP) begin
                            m_rs[i] = 1'b0;
                            m_fs[i] = 1'b0;
                        end
                    end
                end
            end
        end
        m_prev = s;
    endtask

    task automatic tick(input logic [W-1:0] s, input logic e,
                        input logic c, input logic r);
        sig   = s;
        en    = e;
        clear = c;
        reset = r;
        @(posedge clock);
        model_step(s, e, c, r);
        #2;
        chk("valid", 128'(valid), 128'(m_valid));
        chk("covered_cnt", 128'(covered_cnt), 128'(m_cnt));
        chk("all_covered", 128'(all_covered), 128'(m_cnt == W));
    endtask

    task automatic restart(input logic [W-1:0] s);
        tick(s, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WARM + 1; i++)
            tick(s, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_edges = 0;
        m_cnt = 0;
        m_prev = '0;
        m_rs = '0;
        m_fs = '0;
        m_cov = '0;
        m_valid = '0;
        ones = '1;
        cur = '0;
        sig = '0;
        en = 1'b0;
        clear = 1'b0;
        reset = 1'b1;

        tick(cur, 1'b0, 1'b0, 1'b1);
        tick(cur, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_cnt", 128'(covered_cnt), 128'(0));
        chk("rst_all", 128'(all_covered), 128'(0));

        // Toggling through warmup, prime and the first RUN edge.
        for (int i = 0; i < WARM + 2; i++) begin
            cur = ~cur;
            tick(cur, 1'b1, 1'b0, 1'b0);
        end
        chk("warm_valid", 128'(valid), 128'(0));
        chk("warm_cnt", 128'(covered_cnt), 128'(0));

        // Single bit rise then fall two edges later.
        cur = '0;
        restart(cur);
        tick(bit1(3), 1'b1, 1'b0, 1'b0);
        tick(bit1(3), 1'b1, 1'b0, 1'b0);
        chk("b3_early", 128'(valid), 128'(0));
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("b3_pulse", 128'(valid), 128'(bit1(3)));
        chk("b3_cnt", 128'(covered_cnt), 128'(1));
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("b3_once", 128'(valid), 128'(0));

        // Every bit at once.
        restart('0);
        tick(ones, 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("all_valid", 128'(valid), 128'(ones));
        chk("all_cnt", 128'(covered_cnt), 128'(65));
        chk("all_flag", 128'(all_covered), 128'(1));

        // Clear on the completing edge of bit 7.
        restart('0);
        tick(bit1(7), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b1, 1'b0);
        chk("clr_valid", 128'(valid), 128'(0));
        chk("clr_cnt", 128'(covered_cnt), 128'(0));
        tick(bit1(7), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("clr_warm", 128'(valid), 128'(0));
        for (int i = 0; i < WARM - 1; i++)
            tick('0, 1'b1, 1'b0, 1'b0);

        // Fall of bit 10 lost while en is low.
        tick(bit1(10), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0);
        chk("en_off", 128'(valid), 128'(0));
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("en_lost", 128'(valid), 128'(0));
        tick(bit1(10), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("en_pulse", 128'(valid), 128'(bit1(10)));
        chk("en_cnt", 128'(covered_cnt), 128'(1));
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("en_once", 128'(valid), 128'(0));

        // Bit 0 toggles twice.
        restart('0);
        tick(bit1(0), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("rep_p1", 128'(valid), 128'(bit1(0)));
        tick(bit1(0), 1'b1, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0, 1'b0);
        chk("rep_p2", 128'(valid), REP ? 128'(bit1(0)) : 128'(0));
        chk("rep_cnt", 128'(covered_cnt), 128'(1));

        // Random traffic with sparse clears and resets.
        cur = '0;
        for (int n = 0; n < 4000; n++) begin
            logic [W-1:0] flip;
            logic e;
            logic c;
            logic r;
            flip = W'({$urandom(), $urandom(), $urandom()})
                 & W'({$urandom(), $urandom(), $urandom()})
                 & W'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 49) == 0)
                flip = ones;
            cur = cur ^ flip;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 249) == 0);
            r = ($urandom_range(0, 499) == 0);
            tick(cur, e, c, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
